approx_cmp_error_monitor: RTL and testbench

- Sequential error-characterization monitor for the approximate comparators. It sits at the output end of an approximate comparator.
- It accepts operand pairs plus the comparator's three approximate flags over a valid/ready handshake, and computes the exact relation internally.
- Over a window of WINDOW samples it accumulates mismatch statistics, then presents them on a held report handshake for the area/accuracy evaluation flow.

---
 rtl/approx_cmp_error_monitor.sv | 152 +++++++++++++++
 tb/tb_approx_cmp_error_monitor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/approx_cmp_error_monitor.sv
// Purpose : measures how often an approximate comparator's eq/gt/lt flags
//           disagree with the exact unsigned relation, over a WINDOW of samples.
// Latency : a sample accepted at edge k reaches the counters at edge k+1;
//           report_valid rises one edge after the last accept.
// Backpr. : in_ready is high only in RUN, never stalls before the window fills;
//           the report is held unchanged until report_ready is seen.
// Ports   : clk/rst (async, active-high); start/busy/done control;
//           in_valid/in_ready + a/b + apx_eq/gt/lt sample input;
//           report_valid/report_ready + six CNT_W statistics counters.
module approx_cmp_error_monitor #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 256,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             apx_eq,
  input  logic             apx_gt,
  input  logic             apx_lt,
  output logic             report_valid,
  input  logic             report_ready,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mis_cnt,
  output logic [CNT_W-1:0] eq_err_cnt,
  output logic [CNT_W-1:0] gt_err_cnt,
  output logic [CNT_W-1:0] lt_err_cnt,
  output logic [CNT_W-1:0] nores_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_REPORT
  } state_t;

  // Accept count that marks the final sample of a window.
  localparam logic [CNT_W-1:0] LAST_ACC = CNT_W'(WINDOW - 1);

  state_t           state_q;
  logic             done_q;
  logic [CNT_W-1:0] acc_q;

  // One-deep stage: holds the already-classified error terms of the sample
  // captured on the previous edge, so the counters lag the accept by one edge.
  logic stg_vld_q;
  logic stg_eq_err_q, stg_gt_err_q, stg_lt_err_q, stg_nores_q;
  logic stg_eq_err_d, stg_gt_err_d, stg_lt_err_d, stg_nores_d;

  logic [CNT_W-1:0] sample_cnt_q, mis_cnt_q, eq_err_cnt_q;
  logic [CNT_W-1:0] gt_err_cnt_q, lt_err_cnt_q, nores_cnt_q;

  // Classification of the sample currently on the input port.
  always_comb begin
    stg_eq_err_d = apx_eq ^ (a == b);
    stg_gt_err_d = apx_gt ^ (a > b);
    stg_lt_err_d = apx_lt ^ (a < b);
    stg_nores_d  = ~(apx_eq | apx_gt | apx_lt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      done_q       <= 1'b0;
      acc_q        <= '0;
      stg_vld_q    <= 1'b0;
      stg_eq_err_q <= 1'b0;
      stg_gt_err_q <= 1'b0;
      stg_lt_err_q <= 1'b0;
      stg_nores_q  <= 1'b0;
      sample_cnt_q <= '0;
      mis_cnt_q    <= '0;
      eq_err_cnt_q <= '0;
      gt_err_cnt_q <= '0;
      lt_err_cnt_q <= '0;
      nores_cnt_q  <= '0;
    end else begin
      done_q    <= 1'b0;
      stg_vld_q <= 1'b0;

      // Retire the staged sample; stage is only ever valid in RUN or DRAIN.
      if (stg_vld_q) begin
        sample_cnt_q <= sample_cnt_q + CNT_W'(1);
        mis_cnt_q    <= mis_cnt_q + CNT_W'(stg_eq_err_q | stg_gt_err_q | stg_lt_err_q);
        eq_err_cnt_q <= eq_err_cnt_q + CNT_W'(stg_eq_err_q);
        gt_err_cnt_q <= gt_err_cnt_q + CNT_W'(stg_gt_err_q);
        lt_err_cnt_q <= lt_err_cnt_q + CNT_W'(stg_lt_err_q);
        nores_cnt_q  <= nores_cnt_q + CNT_W'(stg_nores_q);
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_RUN;
            acc_q        <= '0;
            sample_cnt_q <= '0;
            mis_cnt_q    <= '0;
            eq_err_cnt_q <= '0;
            gt_err_cnt_q <= '0;
            lt_err_cnt_q <= '0;
            nores_cnt_q  <= '0;
          end
        end
        S_RUN: begin
          // in_ready is 1 throughout RUN, so in_valid alone is the handshake.
          if (in_valid) begin
            stg_vld_q    <= 1'b1;
            stg_eq_err_q <= stg_eq_err_d;
            stg_gt_err_q <= stg_gt_err_d;
            stg_lt_err_q <= stg_lt_err_d;
            stg_nores_q  <= stg_nores_d;
            acc_q        <= acc_q + CNT_W'(1);
            if (acc_q == LAST_ACC) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          state_q <= S_REPORT;
        end
        S_REPORT: begin
          if (report_ready) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign in_ready     = (state_q == S_RUN);
  assign report_valid = (state_q == S_REPORT);
  assign done         = done_q;
  assign sample_cnt   = sample_cnt_q;
  assign mis_cnt      = mis_cnt_q;
  assign eq_err_cnt   = eq_err_cnt_q;
  assign gt_err_cnt   = gt_err_cnt_q;
  assign lt_err_cnt   = lt_err_cnt_q;
  assign nores_cnt    = nores_cnt_q;

endmodule

// File: tb/tb_approx_cmp_error_monitor.sv
module tb_approx_cmp_error_monitor;

  localparam int WIDTH  = 8;
  localparam int WINDOW = 4;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             busy, done, in_ready, report_valid;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             apx_eq = 1'b0, apx_gt = 1'b0, apx_lt = 1'b0;
  logic             report_ready = 1'b0;
  logic [CNT_W-1:0] sample_cnt, mis_cnt, eq_err_cnt, gt_err_cnt, lt_err_cnt, nores_cnt;

  approx_cmp_error_monitor #(.WIDTH(WIDTH), .WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .apx_eq(apx_eq), .apx_gt(apx_gt), .apx_lt(apx_lt),
    .report_valid(report_valid), .report_ready(report_ready),
    .sample_cnt(sample_cnt), .mis_cnt(mis_cnt), .eq_err_cnt(eq_err_cnt),
    .gt_err_cnt(gt_err_cnt), .lt_err_cnt(lt_err_cnt), .nores_cnt(nores_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned a;
    int unsigned b;
    bit          eq;
    bit          gt;
    bit          lt;
  } smp_t;

  smp_t accepted[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are observed 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Presents one sample for one cycle; it is recorded only if the handshake completes.
  task automatic send(input int unsigned aa, input int unsigned bb,
                      input bit e, input bit g, input bit l);
    smp_t s;
    a = aa[WIDTH-1:0]; b = bb[WIDTH-1:0];
    apx_eq = e; apx_gt = g; apx_lt = l;
    in_valid = 1'b1;
    s.a = aa; s.b = bb; s.eq = e; s.gt = g; s.lt = l;
    if (in_ready) accepted.push_back(s);
    tick();
    in_valid = 1'b0;
  endtask

  // Reference: tally the window directly from the arithmetic definition of each statistic.
  task automatic check_report(input string tag);
    int n_s = 0, n_m = 0, n_e = 0, n_g = 0, n_l = 0, n_n = 0;
    foreach (accepted[i]) begin
      bit ex_eq, ex_gt, ex_lt, fe, fg, fl;
      ex_eq = (accepted[i].a == accepted[i].b);
      ex_gt = (accepted[i].a >  accepted[i].b);
      ex_lt = (accepted[i].a <  accepted[i].b);
      fe = (accepted[i].eq != ex_eq);
      fg = (accepted[i].gt != ex_gt);
      fl = (accepted[i].lt != ex_lt);
      n_s++;
      if (fe || fg || fl) n_m++;
      if (fe) n_e++;
      if (fg) n_g++;
      if (fl) n_l++;
      if (!accepted[i].eq && !accepted[i].gt && !accepted[i].lt) n_n++;
    end
    chk({tag, ".sample"}, 32'(sample_cnt), 32'(n_s));
    chk({tag, ".mis"},    32'(mis_cnt),    32'(n_m));
    chk({tag, ".eq_err"}, 32'(eq_err_cnt), 32'(n_e));
    chk({tag, ".gt_err"}, 32'(gt_err_cnt), 32'(n_g));
    chk({tag, ".lt_err"}, 32'(lt_err_cnt), 32'(n_l));
    chk({tag, ".nores"},  32'(nores_cnt),  32'(n_n));
  endtask

  // Called right after the edge of the last accept: checks DRAIN/REPORT timing,
  // the statistics, an optional report stall, and the done pulse.
  task automatic finish_window(input string tag, input int stall);
    logic [CNT_W-1:0] held;
    chk({tag, ".rv_after_k"}, 32'(report_valid), 32'd0);
    chk({tag, ".in_ready_drain"}, 32'(in_ready), 32'd0);
    chk({tag, ".busy_drain"}, 32'(busy), 32'd1);
    tick();
    chk({tag, ".rv_after_k1"}, 32'(report_valid), 32'd1);
    check_report(tag);
    held = sample_cnt;
    for (int i = 0; i < stall; i++) begin
      if (i == 2) start = 1'b1;
      in_valid = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b0;
      chk({tag, ".stall_rv"}, 32'(report_valid), 32'd1);
      chk({tag, ".stall_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, ".stall_hold"}, 32'(sample_cnt), 32'(held));
      chk({tag, ".stall_done"}, 32'(done), 32'd0);
    end
    if (stall > 0) check_report({tag, ".post_stall"});
    report_ready = 1'b1;
    tick();
    report_ready = 1'b0;
    chk({tag, ".done_hi"}, 32'(done), 32'd1);
    chk({tag, ".busy_lo"}, 32'(busy), 32'd0);
    chk({tag, ".rv_lo"}, 32'(report_valid), 32'd0);
    tick();
    chk({tag, ".done_once"}, 32'(done), 32'd0);
    check_report({tag, ".idle_hold"});
    accepted.delete();
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.rv", 32'(report_valid), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.sample", 32'(sample_cnt), 32'd0);
    chk("rst.mis", 32'(mis_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle.in_ready", 32'(in_ready), 32'd0);

    // 1. Exact-correct flags
    pulse_start();
    chk("t1.busy", 32'(busy), 32'd1);
    chk("t1.in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) send(32'h80, 32'h10, 1'b0, 1'b1, 1'b0);
    chk("t1.const_sample", 32'(sample_cnt), 32'd3);
    finish_window("t1", 0);
    chk("t1.const_final", 32'(sample_cnt), 32'd4);
    chk("t1.const_mis", 32'(mis_cnt), 32'd0);

    // 2. Approximate-comparator misses
    pulse_start();
    send(32'h05, 32'h06, 1'b1, 1'b0, 1'b0);
    send(32'h14, 32'h18, 1'b0, 1'b0, 1'b0);
    send(32'h05, 32'h06, 1'b1, 1'b0, 1'b0);
    send(32'h14, 32'h18, 1'b0, 1'b0, 1'b0);
    finish_window("t2", 0);
    chk("t2.const_mis", 32'(mis_cnt), 32'd4);
    chk("t2.const_eq", 32'(eq_err_cnt), 32'd2);
    chk("t2.const_lt", 32'(lt_err_cnt), 32'd4);
    chk("t2.const_nores", 32'(nores_cnt), 32'd2);
    chk("t2.const_gt", 32'(gt_err_cnt), 32'd0);

    // 3. Handshake gaps: an idle cycle with changing data between accepts
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send($urandom_range(0, 255), $urandom_range(0, 255),
           1'($urandom), 1'($urandom), 1'($urandom));
      if (i < 3) begin
        a = 8'($urandom); b = 8'($urandom); apx_eq = 1'b1;
        tick();
      end
    end
    finish_window("t3", 0);

    // 4. Report backpressure with an ignored start
    pulse_start();
    for (int i = 0; i < 4; i++) send(i * 3, 5, 1'b0, 1'b1, 1'b0);
    finish_window("t4", 5);
    tick();
    chk("t4.no_restart", 32'(busy), 32'd0);

    // 5. Reset mid-RUN, then a clean window
    pulse_start();
    send(32'h11, 32'h11, 1'b0, 1'b0, 1'b0);
    send(32'h22, 32'h11, 1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #2;
    chk("t5.rst_busy", 32'(busy), 32'd0);
    chk("t5.rst_in_ready", 32'(in_ready), 32'd0);
    chk("t5.rst_sample", 32'(sample_cnt), 32'd0);
    chk("t5.rst_mis", 32'(mis_cnt), 32'd0);
    chk("t5.rst_eq", 32'(eq_err_cnt), 32'd0);
    rst = 1'b0;
    accepted.delete();
    tick();
    chk("t5.stay_idle", 32'(busy), 32'd0);
    pulse_start();
    for (int i = 0; i < 4; i++) send(32'h40, 32'h40, 1'b1, 1'b0, 1'b0);
    finish_window("t5", 0);
    chk("t5.const_sample", 32'(sample_cnt), 32'd4);

    // Randomised windows: narrow operand range so equality is common, random gaps
    for (int w = 0; w < 12; w++) begin
      int got;
      pulse_start();
      got = 0;
      while (got < 4) begin
        if ($urandom_range(0, 2) == 0) begin
          tick();
        end else begin
          send($urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom), 1'($urandom), 1'($urandom));
          got++;
        end
      end
      finish_window($sformatf("rnd%0d", w), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
